// File: rtl/and_unit_arbiter_if.sv
// Requester-side bundle for and_unit_arbiter.
// master: requesting datapaths; slave: the arbiter.
interface and_unit_arbiter_if #(
    parameter int NREQ  = 4,
    parameter int WIDTH = 8,
    parameter int ID_W  = $clog2(NREQ)
) ();

    logic [NREQ-1:0]       req;
    logic [NREQ*WIDTH-1:0] op_a;
    logic [NREQ*WIDTH-1:0] op_b;
    logic [NREQ-1:0]       gnt;
    logic                  rsp_valid;
    logic [ID_W-1:0]       rsp_id;
    logic [WIDTH-1:0]      rsp_data;

    modport master (
        output req,
        output op_a,
        output op_b,
        input  gnt,
        input  rsp_valid,
        input  rsp_id,
        input  rsp_data
    );

    modport slave (
        input  req,
        input  op_a,
        input  op_b,
        output gnt,
        output rsp_valid,
        output rsp_id,
        output rsp_data
    );

endinterface

// File: rtl/and_unit_arbiter.sv
// Round-robin arbiter sharing one external combinational AND unit.
// Ports: clk, rst_n (async low); bus (slave: req/op_a/op_b in,
// gnt/rsp_* out); unit_a/unit_b out to the AND unit, unit_y back;
// busy high while an operation is being evaluated.
module and_unit_arbiter #(
    parameter int NREQ  = 4,
    parameter int WIDTH = 8,
    parameter int ID_W  = $clog2(NREQ)
) (
    input  logic             clk,
    input  logic             rst_n,
    and_unit_arbiter_if.slave bus,
    output logic [WIDTH-1:0] unit_a,
    output logic [WIDTH-1:0] unit_b,
    input  logic [WIDTH-1:0] unit_y,
    output logic             busy
);

    typedef enum logic {
        IDLE,
        EVAL
    } state_e;

    state_e            state_q, state_d;
    logic [NREQ-1:0]   gnt_q, gnt_d;
    logic [WIDTH-1:0]  ua_q, ua_d;
    logic [WIDTH-1:0]  ub_q, ub_d;
    logic              rv_q, rv_d;
    logic [ID_W-1:0]   rid_q, rid_d;
    logic [WIDTH-1:0]  rdat_q, rdat_d;
    logic [ID_W-1:0]   owner_q, owner_d;
    logic [ID_W-1:0]   last_q, last_d;

    logic              win_vld;
    logic [ID_W-1:0]   win_id;
    logic [WIDTH-1:0]  win_a;
    logic [WIDTH-1:0]  win_b;

    // Search starts just after the last winner and wraps, so
    // the most recently served requester has lowest priority.
    always_comb begin
        int idx;
        idx     = 0;
        win_vld = 1'b0;
        win_id  = '0;
        win_a   = '0;
        win_b   = '0;
        for (int k = 1; k <= NREQ; k++) begin
            idx = (int'(last_q) + k) % NREQ;
            if (!win_vld && bus.req[idx]) begin
                win_vld = 1'b1;
                win_id  = ID_W'(idx);
                win_a   = bus.op_a[idx*WIDTH +: WIDTH];
                win_b   = bus.op_b[idx*WIDTH +: WIDTH];
            end
        end
    end

    always_comb begin
        state_d = state_q;
        gnt_d   = '0;
        ua_d    = ua_q;
        ub_d    = ub_q;
        rv_d    = 1'b0;
        rid_d   = rid_q;
        rdat_d  = rdat_q;
        owner_d = owner_q;
        last_d  = last_q;
        unique case (state_q)
            IDLE: begin
                if (win_vld) begin
                    gnt_d   = NREQ'(1) << win_id;
                    ua_d    = win_a;
                    ub_d    = win_b;
                    owner_d = win_id;
                    last_d  = win_id;
                    state_d = EVAL;
                end
            end
            EVAL: begin
                // Unit inputs settled during this cycle.
                rv_d    = 1'b1;
                rid_d   = owner_q;
                rdat_d  = unit_y;
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            gnt_q   <= '0;
            ua_q    <= '0;
            ub_q    <= '0;
            rv_q    <= 1'b0;
            rid_q   <= '0;
            rdat_q  <= '0;
            owner_q <= '0;
            last_q  <= ID_W'(NREQ - 1);
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            ua_q    <= ua_d;
            ub_q    <= ub_d;
            rv_q    <= rv_d;
            rid_q   <= rid_d;
            rdat_q  <= rdat_d;
            owner_q <= owner_d;
            last_q  <= last_d;
        end
    end

    assign bus.gnt       = gnt_q;
    assign bus.rsp_valid = rv_q;
    assign bus.rsp_id    = rid_q;
    assign bus.rsp_data  = rdat_q;
    assign unit_a        = ua_q;
    assign unit_b        = ub_q;
    assign busy          = (state_q == EVAL);

endmodule

// File: tb/tb_and_unit_arbiter.sv
// Self-checking bench for and_unit_arbiter.
// Behavioural model plus directed literal checks.
module tb_and_unit_arbiter;

    localparam int NREQ  = 4;
    localparam int WIDTH = 8;
    localparam int ID_W  = 2;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic [WIDTH-1:0] unit_a, unit_b, unit_y;
    logic busy;
    logic [WIDTH-1:0] a_arr [NREQ];
    logic [WIDTH-1:0] b_arr [NREQ];

    int n_cmp = 0;
    int n_bad = 0;

    and_unit_arbiter_if #(.NREQ(NREQ), .WIDTH(WIDTH)) bus ();

    and_unit_arbiter #(.NREQ(NREQ), .WIDTH(WIDTH)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .bus    (bus),
        .unit_a (unit_a),
        .unit_b (unit_b),
        .unit_y (unit_y),
        .busy   (busy)
    );

    // The shared external AND unit.
    assign unit_y = unit_a & unit_b;

    always #5 clk = ~clk;

    always_comb begin
        for (int i = 0; i < NREQ; i++) begin
            bus.op_a[i*WIDTH +: WIDTH] = a_arr[i];
            bus.op_b[i*WIDTH +: WIDTH] = b_arr[i];
        end
    end

    function automatic void chk(string nm, logic [31:0] act,
                                logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endfunction

    function automatic int pick(logic [NREQ-1:0] r, int last);
        for (int k = 1; k <= NREQ; k++)
            if (r[(last + k) % NREQ]) return (last + k) % NREQ;
        return -1;
    endfunction

    // Model: one operation in flight at most; a grant is
    // followed by its response, then arbitration reopens.
    int  m_last = NREQ - 1;
    bit  m_inflight = 1'b0;
    int  m_owner = 0;
    logic [WIDTH-1:0] m_res = '0;
    logic [NREQ-1:0]  e_gnt = '0;
    logic [WIDTH-1:0] e_ua = '0, e_ub = '0, e_rd = '0;
    logic [ID_W-1:0]  e_rid = '0;
    logic             e_rv = 1'b0;

    always @(posedge clk or negedge rst_n) begin
        int w;
        if (!rst_n) begin
            m_last = NREQ - 1;
            m_inflight = 1'b0;
            m_owner = 0;
            e_gnt = '0; e_ua = '0; e_ub = '0;
            e_rd = '0; e_rid = '0; e_rv = 1'b0;
        end else begin
            e_gnt = '0;
            e_rv  = 1'b0;
            if (m_inflight) begin
                e_rv  = 1'b1;
                e_rid = ID_W'(m_owner);
                e_rd  = m_res;
                m_inflight = 1'b0;
            end else if (bus.req != '0) begin
                w = pick(bus.req, m_last);
                e_gnt = '0;
                e_gnt[w] = 1'b1;
                e_ua = a_arr[w];
                e_ub = b_arr[w];
                m_res = a_arr[w] & b_arr[w];
                m_owner = w;
                m_last = w;
                m_inflight = 1'b1;
            end
        end
    end

    always @(negedge clk) begin
        chk("gnt",       32'(bus.gnt),       32'(e_gnt));
        chk("unit_a",    32'(unit_a),        32'(e_ua));
        chk("unit_b",    32'(unit_b),        32'(e_ub));
        chk("rsp_valid", 32'(bus.rsp_valid), 32'(e_rv));
        chk("rsp_id",    32'(bus.rsp_id),    32'(e_rid));
        chk("rsp_data",  32'(bus.rsp_data),  32'(e_rd));
        chk("busy",      32'(busy),          32'(m_inflight));
    end

    int g_ord [8];
    int r_id  [8];
    int r_dat [8];
    int ng, nr;

    function automatic int oh2i(logic [NREQ-1:0] v);
        for (int i = 0; i < NREQ; i++) if (v[i]) return i;
        return -1;
    endfunction

    // Run n cycles; each requester drops req once granted.
    task automatic run_drop(int n);
        ng = 0;
        nr = 0;
        for (int c = 0; c < n; c++) begin
            @(negedge clk);
            if (bus.gnt != '0 && ng < 8) begin
                g_ord[ng] = oh2i(bus.gnt);
                ng++;
                bus.req = bus.req & ~bus.gnt;
            end
            if (bus.rsp_valid && nr < 8) begin
                r_id[nr]  = int'(bus.rsp_id);
                r_dat[nr] = int'(bus.rsp_data);
                nr++;
            end
        end
    endtask

    initial begin
        int gc, rc;
        bus.req = '0;
        for (int i = 0; i < NREQ; i++) begin
            a_arr[i] = '0;
            b_arr[i] = '0;
        end
        repeat (3) @(negedge clk);
        chk("rst_gnt",  32'(bus.gnt), 32'h0);
        chk("rst_busy", 32'(busy), 32'h0);
        chk("rst_last_rv", 32'(bus.rsp_valid), 32'h0);
        rst_n = 1'b1;
        @(negedge clk);

        // All four requesting, priority from 0.
        for (int i = 0; i < NREQ; i++) begin
            a_arr[i] = 8'hFF;
            b_arr[i] = 8'(8'h11 * (i + 1));
        end
        bus.req = 4'b1111;
        run_drop(12);
        chk("all_ngrants", 32'(ng), 32'd4);
        chk("all_nrsp", 32'(nr), 32'd4);
        for (int i = 0; i < 4; i++) begin
            chk("all_gnt_order", 32'(g_ord[i]), 32'(i));
            chk("all_rsp_id", 32'(r_id[i]), 32'(i));
            chk("all_rsp_data", 32'(r_dat[i]), 32'(8'h11 * (i + 1)));
        end

        // Single request from requester 2.
        a_arr[2] = 8'hF0;
        b_arr[2] = 8'h3C;
        bus.req = 4'b0100;
        @(negedge clk);
        chk("one_gnt", 32'(bus.gnt), 32'h4);
        chk("one_ua", 32'(unit_a), 32'hF0);
        chk("one_ub", 32'(unit_b), 32'h3C);
        chk("one_busy", 32'(busy), 32'h1);
        bus.req = '0;
        @(negedge clk);
        chk("one_rv", 32'(bus.rsp_valid), 32'h1);
        chk("one_id", 32'(bus.rsp_id), 32'h2);
        chk("one_data", 32'(bus.rsp_data), 32'h30);
        chk("one_gnt_off", 32'(bus.gnt), 32'h0);

        // Fairness after serving 2.
        bus.req = 4'b1001;
        run_drop(6);
        chk("fair_ng", 32'(ng), 32'd2);
        chk("fair_first", 32'(g_ord[0]), 32'd3);
        chk("fair_second", 32'(g_ord[1]), 32'd0);

        // Held request on 0.
        bus.req = 4'b0001;
        gc = 0;
        rc = 0;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            if (bus.gnt == 4'b0001) gc++;
            if (bus.rsp_valid) rc++;
        end
        chk("held_gnts", 32'(gc), 32'd4);
        chk("held_rsps", 32'(rc), 32'd4);
        bus.req = '0;
        repeat (2) @(negedge clk);

        // Asynchronous reset between edges.
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        chk("arst_gnt", 32'(bus.gnt), 32'h0);
        chk("arst_ua", 32'(unit_a), 32'h0);
        chk("arst_ub", 32'(unit_b), 32'h0);
        chk("arst_rv", 32'(bus.rsp_valid), 32'h0);
        chk("arst_id", 32'(bus.rsp_id), 32'h0);
        chk("arst_data", 32'(bus.rsp_data), 32'h0);
        chk("arst_busy", 32'(busy), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        bus.req = 4'b0001;
        @(negedge clk);
        chk("arst_first_gnt", 32'(bus.gnt), 32'h1);
        bus.req = '0;
        repeat (2) @(negedge clk);

        // Reset while evaluating.
        bus.req = 4'b0100;
        @(posedge clk);
        #2;
        chk("eval_busy", 32'(busy), 32'h1);
        rst_n = 1'b0;
        #1;
        chk("eval_rst_busy", 32'(busy), 32'h0);
        chk("eval_rst_rv", 32'(bus.rsp_valid), 32'h0);
        @(negedge clk);
        chk("eval_no_rsp", 32'(bus.rsp_valid), 32'h0);
        rst_n = 1'b1;
        bus.req = 4'b1010;
        @(negedge clk);
        chk("eval_after_gnt", 32'(bus.gnt), 32'h2);
        bus.req = '0;
        repeat (4) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
